snn_weight_sequencer: RTL and testbench



---
 rtl/snn_pkg.sv | 19 +
 rtl/snn_weight_regfile.sv | 28 ++
 rtl/snn_weight_sequencer.sv | 171 +++++++++++++++++
 tb/tb_snn_weight_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network weight sequencer.
package snn_pkg;

    localparam int WEIGHT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        L1,
        L2_WAIT,
        CAPTURE,
        DONE
    } state_t;

    function automatic int weight_slice(input int k);
        return k * WEIGHT_W;
    endfunction

endpackage

// File: rtl/snn_weight_regfile.sv
// NUM_W x 4-bit signed weight register file with synchronous clear.
module snn_weight_regfile
    import snn_pkg::*;
#(
    parameter int NUM_W = 6,
    parameter int IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      we,
    input  logic [IDX_W-1:0]          widx,
    input  logic [WEIGHT_W-1:0]       wdata,
    output logic [NUM_W*WEIGHT_W-1:0] weights
);

    always_ff @(posedge clk) begin
        if (clr) begin
            weights <= '0;
        end else if (we) begin
            for (int k = 0; k < NUM_W; k++) begin
                if (widx == IDX_W'(k)) begin
                    weights[weight_slice(k) +: WEIGHT_W] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/snn_weight_sequencer.sv
// Weight fetch and layer sequencing for one inference.
// Optional weight cache enabled by SNN_WEIGHT_CACHE_EN.
module snn_weight_sequencer
    import snn_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DW      = 8,
    parameter int NUM_W   = 6,
    parameter int L2_LAT  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      w_req,
    output logic [ADDR_W-1:0]         w_addr,
    input  logic                      w_valid,
    input  logic [DW-1:0]             w_data,
    output logic [NUM_W*WEIGHT_W-1:0] weights,
    output logic                      l1_en,
    output logic                      l2_en,
    input  logic [7:0]                prediction_in,
    output logic [7:0]                prediction,
    output logic                      busy,
    output logic                      done,
`ifdef SNN_WEIGHT_CACHE_EN
    input  logic                      wt_invalidate,
`endif
    output logic                      err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(L2_LAT + 1);

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] idx;
    logic [TW-1:0]     tcnt;
    logic [LW-1:0]     lcnt;
    logic              go;
    logic              wr_en;
    logic              fetch_ok;
    logic              t_out;
    logic              last;
    logic              use_cache;

    assign last = (idx == ADDR_W'(NUM_W - 1));

`ifdef SNN_WEIGHT_CACHE_EN
    logic cache_vld;

    // Invalidate beats a same-cycle start so that start refetches.
    assign use_cache = cache_vld && !wt_invalidate;

    always_ff @(posedge clk) begin
        if (rst || t_out || wt_invalidate) begin
            cache_vld <= 1'b0;
        end else if (fetch_ok) begin
            cache_vld <= 1'b1;
        end
    end
`else
    assign use_cache = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        go       = 1'b0;
        wr_en    = 1'b0;
        fetch_ok = 1'b0;
        t_out    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    go  = 1'b1;
                    nxt = use_cache ? L1 : FETCH;
                end
            end
            FETCH: begin
                // A word arriving on the final wait cycle still succeeds.
                if (w_valid) begin
                    wr_en = 1'b1;
                    if (last) begin
                        fetch_ok = 1'b1;
                        nxt      = L1;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    t_out = 1'b1;
                    nxt   = DONE;
                end
            end
            L1:      nxt = L2_WAIT;
            L2_WAIT: begin
                if (lcnt == LW'(L2_LAT - 1)) begin
                    nxt = CAPTURE;
                end
            end
            CAPTURE: nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            tcnt       <= '0;
            lcnt       <= '0;
            err        <= 1'b0;
            prediction <= '0;
        end else begin
            if (go) begin
                idx  <= '0;
                tcnt <= '0;
                err  <= 1'b0;
            end
            if (wr_en) begin
                tcnt <= '0;
                if (!last) begin
                    idx <= idx + ADDR_W'(1);
                end
            end else if (t_out) begin
                tcnt <= '0;
                err  <= 1'b1;
            end else if (state == FETCH) begin
                tcnt <= tcnt + TW'(1);
            end
            if (state == L2_WAIT) begin
                lcnt <= (nxt == CAPTURE) ? '0 : lcnt + LW'(1);
            end
            if (state == CAPTURE) begin
                prediction <= prediction_in;
            end
        end
    end

    generate
        if (DW > WEIGHT_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^w_data[DW-1:WEIGHT_W];
        end
    endgenerate

    snn_weight_regfile #(
        .NUM_W (NUM_W),
        .IDX_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .clr     (rst),
        .we      (wr_en),
        .widx    (idx),
        .wdata   (w_data[WEIGHT_W-1:0]),
        .weights (weights)
    );

    assign w_req  = (state == FETCH);
    assign w_addr = idx;
    assign l1_en  = (state == L1);
    assign l2_en  = (state == L2_WAIT) && (lcnt == '0);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_snn_weight_sequencer.sv
// Scoreboard bench for snn_weight_sequencer with a wait-state memory model.
// Cache tests run when SNN_WEIGHT_CACHE_EN is defined.
module tb_snn_weight_sequencer;

    localparam int NW    = 6;
    localparam int TMO   = 15;
    localparam int L2LAT = 2;

    typedef struct {
        logic [23:0] w;
        logic [7:0]  pred;
        logic        err;
        int          lat;
        int          l1;
        int          l2;
        int          req;
        int          hold;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        w_req;
    logic [3:0]  w_addr;
    logic        w_valid;
    logic [7:0]  w_data;
    logic [23:0] weights;
    logic        l1_en;
    logic        l2_en;
    logic [7:0]  prediction_in;
    logic [7:0]  prediction;
    logic        busy;
    logic        done;
    logic        err;
    logic        wt_invalidate = 1'b0;

    logic [7:0]  mem [16];
    int          dly [16];
    int          wcnt = 0;
    logic        spur = 1'b0;
    logic [1:0]  l2_sh = '0;
    logic [7:0]  dp_pred = 8'h00;

    logic [3:0]  mdl_w [NW];
    logic [7:0]  mdl_pred = 8'h00;
    bit          mdl_cache = 1'b0;
    sb_t         sb [$];

    int cyc = 0;
    int t0 = 0;
    int n_l1 = 0;
    int n_l2 = 0;
    int n_req = 0;
    int n_hold = 0;
    int hold_addr = 0;
    int n_chk = 0;
    int n_pass = 0;

    snn_weight_sequencer #(
        .ADDR_W  (4),
        .DW      (8),
        .NUM_W   (NW),
        .L2_LAT  (L2LAT),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .w_req         (w_req),
        .w_addr        (w_addr),
        .w_valid       (w_valid),
        .w_data        (w_data),
        .weights       (weights),
        .l1_en         (l1_en),
        .l2_en         (l2_en),
        .prediction_in (prediction_in),
        .prediction    (prediction),
        .busy          (busy),
        .done          (done),
`ifdef SNN_WEIGHT_CACHE_EN
        .wt_invalidate (wt_invalidate),
`endif
        .err           (err)
    );

    always #5 clk = ~clk;

    // Memory answers once the per-address wait count has elapsed.
    assign w_valid = spur | (w_req && (wcnt >= dly[w_addr]));
    assign w_data  = spur ? 8'h09 : mem[w_addr];
    // Datapath result is only meaningful L2LAT cycles after l2_en.
    assign prediction_in = l2_sh[1] ? dp_pred : ~dp_pred;

    always @(posedge clk) begin
        l2_sh <= {l2_sh[0], l2_en};
        if (w_req && !w_valid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (start && !busy) begin
                t0     <= cyc;
                n_l1   <= 0;
                n_l2   <= 0;
                n_req  <= 0;
                n_hold <= 0;
            end else begin
                n_l1   <= n_l1 + int'(l1_en);
                n_l2   <= n_l2 + int'(l2_en);
                n_req  <= n_req + int'(w_req);
                n_hold <= n_hold + int'(w_req && (int'(w_addr) == hold_addr));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [23:0] pack();
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < NW; k++) r[4*k +: 4] = mdl_w[k];
        return r;
    endfunction

    task automatic load(input logic [47:0] b);
        for (int k = 0; k < 16; k++) begin
            mem[k] = (k < NW) ? b[8*k +: 8] : 8'h00;
            dly[k] = 0;
        end
    endtask

    task automatic launch(input logic [7:0] pred, input bit inval);
        sb_t e;
        int  f;
        bit  to;
        bit  hit;
        hit    = mdl_cache && !inval;
        f      = 0;
        to     = 1'b0;
        e.hold = 0;
        if (!hit) begin
            for (int k = 0; k < NW; k++) begin
                if (dly[k] >= TMO) begin
                    f += TMO;
                    to = 1'b1;
                    if (k == hold_addr) e.hold = TMO;
                    break;
                end
                f += dly[k] + 1;
                mdl_w[k] = mem[k][3:0];
                if (k == hold_addr) e.hold = dly[k] + 1;
            end
        end
        e.req = f;
        if (to) begin
            e.lat = 1 + f + 1;
            e.err = 1'b1;
            e.l1  = 0;
            e.l2  = 0;
            mdl_cache = 1'b0;
        end else begin
            e.lat = 1 + f + 1 + L2LAT + 1 + 1;
            e.err = 1'b0;
            e.l1  = 1;
            e.l2  = 1;
            mdl_pred = pred;
`ifdef SNN_WEIGHT_CACHE_EN
            mdl_cache = 1'b1;
`endif
        end
        e.pred = mdl_pred;
        e.w    = pack();
        sb.push_back(e);
        dp_pred = pred;
        @(negedge clk);
        start = 1'b1;
        wt_invalidate = inval;
        @(negedge clk);
        start = 1'b0;
        wt_invalidate = 1'b0;
        check("busy_on", busy, 1);
        check("err_clr", err, 0);
        if (hit) begin
            check("hit_l1", l1_en, 1);
        end else begin
            check("req_on", w_req, 1);
            check("addr0", w_addr, 0);
        end
    endtask

    task automatic wait_done(input bit ab_fetch, input bit ab_done);
        sb_t e;
        bit  got;
        got = 1'b0;
        for (int i = 1; i <= 300 && !got; i++) begin
            @(negedge clk);
            if (ab_fetch && i == 1) start = 1'b1;
            if (ab_fetch && i == 2) start = 1'b0;
            if (done) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - t0 + 1, e.lat);
                    check("weights", weights, e.w);
                    check("pred", prediction, e.pred);
                    check("err", err, e.err);
                    check("l1_pulses", n_l1, e.l1);
                    check("l2_pulses", n_l2, e.l2);
                    check("req_cycles", n_req, e.req);
                    check("hold_cycles", n_hold, e.hold);
                    check("req_off", w_req, 0);
                end
            end
        end
        if (!got) begin
            check("done_seen", 0, 1);
            sb.delete();
        end else if (ab_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_start_ign", busy, 0);
            @(negedge clk);
            check("still_idle", busy, 0);
        end
    endtask

    initial begin
        int n;
        bit got;
        for (int k = 0; k < NW; k++) mdl_w[k] = 4'h0;
        load(48'h7E_04_F3_0F_02_A1);

        repeat (2) @(negedge clk);
        check("rst_req", w_req, 0);
        check("rst_addr", w_addr, 0);
        check("rst_w", weights, 0);
        check("rst_l1", l1_en, 0);
        check("rst_l2", l2_en, 0);
        check("rst_pred", prediction, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        hold_addr = 0;
        launch(8'h5C, 1'b0);
        wait_done(1'b0, 1'b0);
        check("nom_w", weights, 24'hE43F21);
        check("nom_pred", prediction, 8'h5C);

        load(48'h48_D7_E6_19_B5_3C);
        dly[2] = 3;
        hold_addr = 2;
        launch(8'h91, 1'b1);
        wait_done(1'b0, 1'b0);

        load(48'h7E_04_F3_0F_02_A1);
        launch(8'h37, 1'b1);
        wait_done(1'b1, 1'b1);

        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        check("spur_w", weights, pack());
        check("spur_busy", busy, 0);

        load(48'h11_22_33_44_55_66);
        dly[4] = 255;
        hold_addr = 4;
        launch(8'hAB, 1'b1);
        wait_done(1'b0, 1'b0);

        load(48'hC8_9A_5B_6D_2E_F1);
        dly[1] = TMO - 1;
        hold_addr = 1;
        launch(8'h4E, 1'b1);
        wait_done(1'b0, 1'b0);

`ifdef SNN_WEIGHT_CACHE_EN
        load(48'h00_00_00_00_00_00);
        hold_addr = 0;
        launch(8'h13, 1'b0);
        wait_done(1'b0, 1'b0);
        load(48'h87_65_43_21_FE_DC);
        @(negedge clk);
        wt_invalidate = 1'b1;
        @(negedge clk);
        wt_invalidate = 1'b0;
        mdl_cache = 1'b0;
        launch(8'h24, 1'b0);
        wait_done(1'b0, 1'b0);
        load(48'h12_34_56_78_9A_BC);
        launch(8'h35, 1'b1);
        wait_done(1'b0, 1'b0);
`endif

        load(48'h7E_04_F3_0F_02_A1);
        launch(8'h66, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (l2_en) got = 1'b1;
        end
        check("l2_reached", got, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < NW; k++) mdl_w[k] = 4'h0;
        mdl_pred = 8'h00;
        mdl_cache = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_w", weights, 0);
        check("mid_pred", prediction, 0);
        check("mid_req", w_req, 0);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            if (done) n++;
        end
        check("mid_nodone", n, 0);

        load(48'h5A_69_78_87_96_A5);
        launch(8'hD2, 1'b0);
        wait_done(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
